// File: rtl/n64_pkg.sv
// Shared types and protocol constants for the N64 controller line engines.
package n64_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StTxLow,
    StTxHigh,
    StTxStop,
    StRxFall,
    StRxSample,
    StRxRise
  } n64_poll_state_t;

  localparam logic [7:0]  CMD_POLL  = 8'h01;
  localparam int unsigned CMD_BITS  = 8;
  localparam int unsigned RESP_BITS = 32;
  localparam int unsigned SAMPLE_US = 2;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/n64_line_sync.sv
// Two-flop synchroniser for the asynchronous N64 data line with registered edge pulses.
module n64_line_sync (
  input  logic clk,
  input  logic Reset,
  input  logic din,
  output logic level,
  output logic fall,
  output logic rise
);

  logic meta_q, sync_q, last_q;

  // Idle line is high, so all history flops reset to 1 to avoid a spurious edge.
  always_ff @(posedge clk) begin
    if (Reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      last_q <= 1'b1;
      fall   <= 1'b0;
      rise   <= 1'b0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      last_q <= sync_q;
      fall   <= last_q & ~sync_q;
      rise   <= ~last_q & sync_q;
    end
  end

  assign level = sync_q;

endmodule

// File: rtl/n64_poll_engine.sv
// Periodically sends the N64 poll command and captures the 32-bit controller response.
module n64_poll_engine
  import n64_pkg::*;
#(
  parameter int unsigned US_TICKS      = 14,
  parameter int unsigned POLL_US       = 16667,
  parameter int unsigned RX_TIMEOUT_US = 100
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        poll_en,
  input  logic        N64_din,
  output logic        N64_oe,
  output logic [31:0] resp_data,
  output logic        resp_valid,
  output logic        timeout_err,
  output logic        busy
);

  localparam int unsigned PollTicks = POLL_US * US_TICKS;
  localparam int unsigned RxTicks   = RX_TIMEOUT_US * US_TICKS;
  localparam int unsigned MaxTicks  = max3(PollTicks, RxTicks, 3 * US_TICKS);
  localparam int unsigned CntW      = (MaxTicks > 1) ? $clog2(MaxTicks) : 1;
  localparam int unsigned IdxW      = $clog2(CMD_BITS);
  localparam int unsigned RxCntW    = $clog2(RESP_BITS + 1);

  localparam logic [CntW-1:0] PollTerm   = CntW'(PollTicks - 1);
  localparam logic [CntW-1:0] RxTerm     = CntW'(RxTicks - 1);
  localparam logic [CntW-1:0] UnitTerm   = CntW'(US_TICKS - 1);
  localparam logic [CntW-1:0] TripleTerm = CntW'(3 * US_TICKS - 1);
  localparam logic [CntW-1:0] SampleTerm = CntW'(SAMPLE_US * US_TICKS - 1);

  n64_poll_state_t    state_q;
  logic [CntW-1:0]    cnt_q;
  logic [IdxW-1:0]    bit_idx_q;
  logic [RxCntW-1:0]  rx_cnt_q;
  logic [31:0]        shift_q;

  logic line_level, line_fall, line_rise;
  logic tx_bit;
  logic [CntW-1:0] low_term, high_term;

  n64_line_sync u_sync (
    .clk   (clk),
    .Reset (Reset),
    .din   (N64_din),
    .level (line_level),
    .fall  (line_fall),
    .rise  (line_rise)
  );

  always_comb begin
    tx_bit    = CMD_POLL[bit_idx_q];
    low_term  = tx_bit ? UnitTerm : TripleTerm;
    high_term = tx_bit ? TripleTerm : UnitTerm;
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_idx_q   <= IdxW'(CMD_BITS - 1);
      rx_cnt_q    <= '0;
      shift_q     <= '0;
      N64_oe      <= 1'b0;
      resp_data   <= '0;
      resp_valid  <= 1'b0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      resp_valid  <= 1'b0;
      timeout_err <= 1'b0;
      case (state_q)
        StIdle: begin
          if (!poll_en) begin
            cnt_q <= '0;
          end else if (cnt_q == PollTerm) begin
            cnt_q     <= '0;
            bit_idx_q <= IdxW'(CMD_BITS - 1);
            N64_oe    <= 1'b1;
            busy      <= 1'b1;
            state_q   <= StTxLow;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StTxLow: begin
          if (cnt_q == low_term) begin
            cnt_q   <= '0;
            N64_oe  <= 1'b0;
            state_q <= StTxHigh;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StTxHigh: begin
          if (cnt_q == high_term) begin
            cnt_q  <= '0;
            N64_oe <= 1'b1;
            if (bit_idx_q == '0) begin
              state_q <= StTxStop;
            end else begin
              bit_idx_q <= bit_idx_q - IdxW'(1);
              state_q   <= StTxLow;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StTxStop: begin
          if (cnt_q == UnitTerm) begin
            cnt_q    <= '0;
            N64_oe   <= 1'b0;
            rx_cnt_q <= '0;
            state_q  <= StRxFall;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StRxFall: begin
          if (line_fall) begin
            cnt_q   <= '0;
            state_q <= StRxSample;
          end else if (cnt_q == RxTerm) begin
            cnt_q       <= '0;
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state_q     <= StIdle;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StRxSample: begin
          if (cnt_q == SampleTerm) begin
            cnt_q    <= '0;
            shift_q  <= {shift_q[30:0], line_level};
            rx_cnt_q <= rx_cnt_q + RxCntW'(1);
            state_q  <= StRxRise;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StRxRise: begin
          // A '1' bit has usually released the line before sampling, so the level counts too.
          if (line_level || line_rise) begin
            cnt_q <= '0;
            if (rx_cnt_q == RxCntW'(RESP_BITS)) begin
              resp_data  <= shift_q;
              resp_valid <= 1'b1;
              busy       <= 1'b0;
              state_q    <= StIdle;
            end else begin
              state_q <= StRxFall;
            end
          end else if (cnt_q == RxTerm) begin
            cnt_q       <= '0;
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state_q     <= StIdle;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: begin
          cnt_q   <= '0;
          N64_oe  <= 1'b0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_n64_poll_engine.sv
// Bench for n64_poll_engine: directed scenarios plus random controller replies.
module tb_n64_poll_engine;

  localparam int unsigned U   = 4;
  localparam int unsigned PUS = 50;
  localparam int unsigned TUS = 10;

  logic        clk = 1'b0;
  logic        Reset;
  logic        poll_en;
  logic        ctrl_rel;
  wire         N64_din;
  logic        N64_oe;
  logic [31:0] resp_data;
  logic        resp_valid;
  logic        timeout_err;
  logic        busy;

  // Open-drain line: low when either side pulls it.
  assign N64_din = ~N64_oe & ctrl_rel;

  always #5 clk = ~clk;

  n64_poll_engine #(
    .US_TICKS      (U),
    .POLL_US       (PUS),
    .RX_TIMEOUT_US (TUS)
  ) dut (
    .clk         (clk),
    .Reset       (Reset),
    .poll_en     (poll_en),
    .N64_din     (N64_din),
    .N64_oe      (N64_oe),
    .resp_data   (resp_data),
    .resp_valid  (resp_valid),
    .timeout_err (timeout_err),
    .busy        (busy)
  );

  int total = 0;
  int bad = 0;
  int n_valid, n_to, n_both, n_wide, n_busy_bad, oe_high_cnt;
  logic prev_valid = 1'b0, prev_to = 1'b0, prev_busy = 1'b0;
  logic [31:0] model_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (resp_valid || timeout_err) begin
      if (busy || !prev_busy) n_busy_bad++;
    end
    if (resp_valid) n_valid++;
    if (timeout_err) n_to++;
    if (resp_valid && timeout_err) n_both++;
    if ((resp_valid && prev_valid) || (timeout_err && prev_to)) n_wide++;
    if (N64_oe) oe_high_cnt++;
    prev_valid = resp_valid;
    prev_to    = timeout_err;
    prev_busy  = busy;
  endtask

  task automatic clear_counts();
    n_valid = 0; n_to = 0; n_both = 0; n_wide = 0; n_busy_bad = 0;
  endtask

  task automatic wait_poll_start(output int n);
    n = 0;
    while (!N64_oe && n < 1000) begin
      tick();
      n++;
    end
    check("poll_started", 32'(N64_oe), 32'd1);
  endtask

  // Command byte and stop bit each end with one release of the line: 9 falls of N64_oe.
  task automatic wait_tx_end();
    int   falls = 0;
    int   n = 0;
    logic p;
    p = N64_oe;
    while (falls < 9 && n < 400) begin
      tick();
      n++;
      if (p && !N64_oe) falls++;
      p = N64_oe;
    end
    check("tx_falls", 32'(falls), 32'd9);
  endtask

  task automatic send_response(input logic [31:0] word, input int nbits, input int gap);
    logic b;
    repeat (gap) tick();
    for (int i = 0; i < nbits; i++) begin
      b = word[31-i];
      ctrl_rel = 1'b0;
      repeat (b ? U : 3 * U) tick();
      ctrl_rel = 1'b1;
      repeat (b ? 3 * U : U) tick();
    end
    if (nbits == 32) begin
      ctrl_rel = 1'b0;
      repeat (U) tick();
      ctrl_rel = 1'b1;
    end
  endtask

  task automatic run_txn(input logic [31:0] word, input int nbits, input bit drop_en);
    int n;
    bit ok;
    ok = (nbits == 32);
    clear_counts();
    wait_tx_end();
    if (drop_en) poll_en = 1'b0;
    send_response(word, nbits, int'($urandom_range(2, 16)));
    n = 0;
    while (n_valid + n_to == 0 && n < 400) begin
      tick();
      n++;
    end
    repeat (20) tick();
    if (ok) model_data = word;
    check("valid_count", 32'(n_valid), ok ? 32'd1 : 32'd0);
    check("timeout_count", 32'(n_to), ok ? 32'd0 : 32'd1);
    check("resp_data", resp_data, model_data);
    check("busy_fall_with_pulse", 32'(n_busy_bad), 32'd0);
    check("pulse_shape", 32'(n_both + n_wide), 32'd0);
  endtask

  initial begin
    int          n;
    int          mism;
    int          idx;
    int          low_len;
    logic [7:0]  cmd;
    logic        exp_oe [132];
    logic [31:0] w;

    Reset      = 1'b1;
    poll_en    = 1'b1;
    ctrl_rel   = 1'b1;
    model_data = 32'h0;
    clear_counts();
    oe_high_cnt = 0;

    // Reset state
    repeat (5) tick();
    check("rst_oe", 32'(N64_oe), 32'd0);
    check("rst_resp_data", resp_data, 32'h0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // First poll lands POLL_US*U cycles after release
    Reset = 1'b0;
    wait_poll_start(n);
    check("first_poll_delay", 32'(n), 32'(PUS * U));
    check("busy_at_tx_start", 32'(busy), 32'd1);

    // Expected N64_oe waveform built from the command byte, MSB first
    cmd = 8'h01;
    idx = 0;
    for (int b = 7; b >= 0; b--) begin
      low_len = cmd[b] ? U : 3 * U;
      for (int j = 0; j < 4 * U; j++) begin
        exp_oe[idx] = (j < low_len);
        idx++;
      end
    end
    for (int j = 0; j < U; j++) begin
      exp_oe[idx] = 1'b1;
      idx++;
    end
    clear_counts();
    mism = 0;
    for (int i = 0; i < 132; i++) begin
      if (N64_oe !== exp_oe[i]) mism++;
      tick();
    end
    check("tx_pattern_mismatches", 32'(mism), 32'd0);
    check("oe_after_tx", 32'(N64_oe), 32'd0);

    // Line left high: timeout RX_TIMEOUT_US*U cycles after the stop bit ends
    n = 0;
    while (!timeout_err && n < 100) begin
      tick();
      n++;
    end
    check("timeout_delay", 32'(n), 32'(TUS * U));
    check("busy_at_timeout", 32'(busy), 32'd0);
    check("resp_data_after_timeout", resp_data, 32'h0);
    check("busy_fall_with_timeout", 32'(n_busy_bad), 32'd0);
    tick();
    check("timeout_width", 32'(timeout_err), 32'd0);

    // Directed reply, then random replies
    wait_poll_start(n);
    run_txn(32'h8000_0001, 32, 1'b0);
    for (int k = 0; k < 3; k++) begin
      w = $urandom();
      wait_poll_start(n);
      run_txn(w, 32, 1'b0);
    end

    // Truncated reply keeps the old word; the next full reply lands
    w = $urandom();
    wait_poll_start(n);
    run_txn(w, 16, 1'b0);
    wait_poll_start(n);
    run_txn(32'h0000_FFFF, 32, 1'b0);

    // Reset during the low phase of command bit 3
    wait_poll_start(n);
    repeat (4 * 4 * U + 2) tick();
    check("oe_in_bit3_low", 32'(N64_oe), 32'd1);
    Reset = 1'b1;
    tick();
    check("oe_after_mid_reset", 32'(N64_oe), 32'd0);
    check("busy_after_mid_reset", 32'(busy), 32'd0);
    check("resp_data_after_mid_reset", resp_data, 32'h0);
    model_data = 32'h0;
    tick();
    Reset = 1'b0;
    wait_poll_start(n);
    check("poll_delay_after_reset", 32'(n), 32'(PUS * U));
    w = $urandom();
    run_txn(w, 32, 1'b0);

    // poll_en dropped during RX: reply completes, no further polls
    w = $urandom();
    wait_poll_start(n);
    run_txn(w, 32, 1'b1);
    oe_high_cnt = 0;
    repeat (1000) tick();
    check("no_poll_after_disable", 32'(oe_high_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
